led_shift_sequencer: RTL
========================

Name: led_shift_sequencer

Overview:
- Controller for the 8-bit LED shift-register datapath.
- Turns raw board keys into commands: run/pause, direction, mode, speed, clear and inject.
- Generates the variable-rate shift tick and sequences the register through shift-in, rotate and bounce patterns.
- Sits in hackathon_top between `key` and `led`; LCD, 7-segment and GPIO are untouched.

Parameters:
- WIDTH, 8: shift register / LED width.
- DIV_BITS, 23: base divider exponent; tick period = 2^(DIV_BITS-speed) clocks; must be >= 8.
- SEED, 8'hFF: register value at reset and on clear.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- key  input  8  raw buttons, active-high, asynchronous to clock.
- led  output  WIDTH  shift register contents.
- mode  output  2  0=SHIFT_IN, 1=ROTATE, 2=BOUNCE (3 unused).
- dir  output  1  0=right (toward bit 0), 1=left.
- running  output  1  1 while stepping on ticks.
- speed  output  3  0 (slowest) .. 7.
- step_pulse  output  1  one-cycle pulse on each applied shift.

Behaviour:
- Reset values (async, reset_n low): led=SEED, mode=SHIFT_IN, dir=0, running=1, speed=0, step_pulse=0, divider=max, sync/edge regs=0.
- Key path:
  - key passes through a 2-flop synchronizer, then rising-edge detect against the previous synchronized value.
  - A command issued by a key edge is visible on the outputs 3 clock edges after key is first sampled high.
  - key[7] is used as a synchronized level, not an edge.
- Key map (edges): key[0] toggle running; key[1] toggle dir; key[2] mode cycles 0->1->2->0; key[3] speed+1, saturating at 7; key[4] speed-1, saturating at 0; key[6] clear.
- Divider:
  - Down-counter reloaded with 2^(DIV_BITS-speed)-1.
  - tick is asserted when the count is 0 and running=1.
  - A speed change reloads the counter immediately.
  - While paused the counter holds.
- Step on tick, by mode:
  - SHIFT_IN: dir=0 -> {key7, led[W-1:1]}; dir=1 -> {led[W-2:0], key7}.
  - ROTATE: circular shift in dir.
  - BOUNCE:
    - One-hot walk in dir.
    - If dir=1 and led[W-1]=1: dir<=0 and shift right this step.
    - If dir=0 and led[0]=1: dir<=1 and shift left this step.
    - Never emits all-zero.
- Mode entry loads:
  - ROTATE: if led==0, load 1.
  - BOUNCE: load 1, dir<=1.
  - SHIFT_IN: contents kept.
- step_pulse is high in the same cycle the register updates.
- Simultaneous events, priority clear > mode change > dir toggle > run toggle > tick:
  - clear: led=SEED, mode kept, and any tick in that cycle is dropped.
  - Mode change with tick in the same cycle: the load wins and the tick is dropped.
  - Dir toggle with tick in the same cycle: the step uses the new dir.
  - key[3] and key[4] edges in the same cycle: speed unchanged.
- Reset mid-operation: everything returns to reset values at once; no pending command survives.

Optional Feature:
- LED_SHIFT_SEQ_STEP_EN defined:
  - key[5] edge while running=0 forces exactly one step (same rules as a tick, step_pulse=1).
  - key[5] is ignored while running=1.
- Undefined: key[5] is ignored entirely.

Decomposition:
- Package led_shift_seq_pkg:
  - mode_e enum (SHIFT_IN, ROTATE, BOUNCE).
  - key index constants (KEY_RUN=0, KEY_DIR=1, KEY_MODE=2, KEY_FAST=3, KEY_SLOW=4, KEY_STEP=5, KEY_CLR=6, KEY_INJ=7).
  - SPEED_MAX=7.
- One sub-module shift_reg_datapath:
  - Inputs: WIDTH register, op (hold/shift-in/rotate/load), dir, in_bit, load value.
  - Holds no control state.
  - The controller FSM and the divider live in led_shift_sequencer.

Test Plan:
1. DIV_BITS=8, release reset, keys 0 -> led FF, 7F, 3F, 1F ... one step every 256 clocks, step_pulse each step; led 00 after 8 steps.
2. Hold key[7]=1 during SHIFT_IN, dir=0 -> led stays FF. Then press key[1] and release key[7] -> 0s enter at bit 0: FE, FC, ...
3. Press key[2] twice (BOUNCE) -> led=01, dir=1. Ticks give 02, 04 ... 80, then 40 with dir=0, then down to 01 and dir=1 again.
4. Press key[3] three times -> speed=3, period 32 clocks at DIV_BITS=8. Press key[3] 5 more -> speed saturates at 7. Press key[3] and key[4] in the same cycle -> no change.
5. Press key[0] -> running=0, no step_pulse for 4 periods. With the macro, a key[5] edge gives exactly one step; without the macro, no step.
6. Press key[6] in the same cycle as a tick -> led=SEED, no step_pulse. Assert reset_n=0 mid-bounce -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/led_shift_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_shift_seq_pkg
//  Description : Shared types and constants for the LED shift sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_shift_seq_pkg;

    typedef enum logic [1:0] {
        SHIFT_IN = 2'd0,
        ROTATE   = 2'd1,
        BOUNCE   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        OP_HOLD     = 2'd0,
        OP_SHIFT_IN = 2'd1,
        OP_ROTATE   = 2'd2,
        OP_LOAD     = 2'd3
    } op_e;

    localparam int KEY_RUN  = 0;
    localparam int KEY_DIR  = 1;
    localparam int KEY_MODE = 2;
    localparam int KEY_FAST = 3;
    localparam int KEY_SLOW = 4;
    localparam int KEY_STEP = 5;
    localparam int KEY_CLR  = 6;
    localparam int KEY_INJ  = 7;

    localparam logic [2:0] SPEED_MAX = 3'd7;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            SHIFT_IN: return ROTATE;
            ROTATE:   return BOUNCE;
            default:  return SHIFT_IN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_shift_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_shift_sequencer_if
//  Description : Key inputs and LED/status outputs of the shift sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_shift_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [7:0]       key;
    logic [WIDTH-1:0] led;
    logic [1:0]       mode;
    logic             dir;
    logic             running;
    logic [2:0]       speed;
    logic             step_pulse;

    modport master (
        output key,
        input  led, mode, dir, running, speed, step_pulse
    );

    modport slave (
        input  key,
        output led, mode, dir, running, speed, step_pulse
    );
endinterface
`default_nettype wire

// File: rtl/shift_reg_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_datapath
//  Description : LED shift register with hold / shift-in / rotate / load ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_datapath
    import led_shift_seq_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hFF)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  op_e              op,
    input  logic             dir,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    // dir=1 moves data toward the MSB, dir=0 toward bit 0
    always_comb begin
        w_next = r_q;
        case (op)
            OP_SHIFT_IN: w_next = dir ? {r_q[WIDTH-2:0], in_bit} : {in_bit, r_q[WIDTH-1:1]};
            OP_ROTATE:   w_next = dir ? {r_q[WIDTH-2:0], r_q[WIDTH-1]} : {r_q[0], r_q[WIDTH-1:1]};
            OP_LOAD:     w_next = load_val;
            default:     w_next = r_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= SEED;
        end else begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/led_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_shift_sequencer
//  Description : Key decoding, rate divider and pattern control for the LED
//                shift register. Define LED_SHIFT_SEQ_STEP_EN for single-step.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_shift_sequencer
    import led_shift_seq_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DIV_BITS = 23,
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(8'hFF)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    led_shift_sequencer_if.slave bus
);

    localparam logic [DIV_BITS-1:0] c_div_all_ones = '1;
    localparam logic [DIV_BITS-1:0] c_div_one      = DIV_BITS'(1);
    localparam logic [WIDTH-1:0]    c_led_one      = WIDTH'(1);

    logic [7:0]          r_key_s1;
    logic [7:0]          r_key_s2;
    logic [7:0]          r_key_prev;
    logic [7:0]          w_edge;

    mode_e               r_mode;
    mode_e               w_mode_nxt;
    logic                r_dir;
    logic                w_dir_nxt;
    logic                r_running;
    logic                w_running_nxt;
    logic [2:0]          r_speed;
    logic [2:0]          w_speed_nxt;
    logic [DIV_BITS-1:0] r_count;
    logic [DIV_BITS-1:0] w_count_nxt;
    logic                r_step_pulse;

    logic                w_clear;
    logic                w_mode_chg;
    logic                w_dir_eff;
    logic                w_tick;
    logic                w_step_req;
    logic                w_do_step;
    logic                w_inj;
    op_e                 w_op;
    logic                w_step_dir;
    logic [WIDTH-1:0]    w_load_val;
    logic [WIDTH-1:0]    w_led;
    logic                w_unused;

    // Keys are asynchronous: two-flop synchronizer, then edge detect
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_key_s1   <= '0;
            r_key_s2   <= '0;
            r_key_prev <= '0;
        end else begin
            r_key_s1   <= bus.key;
            r_key_s2   <= r_key_s1;
            r_key_prev <= r_key_s2;
        end
    end

    assign w_edge     = r_key_s2 & ~r_key_prev;
    assign w_inj      = r_key_s2[KEY_INJ];
    assign w_clear    = w_edge[KEY_CLR];
    assign w_mode_chg = w_edge[KEY_MODE] & ~w_clear;
    assign w_dir_eff  = r_dir ^ w_edge[KEY_DIR];
    assign w_tick     = r_running && (r_count == '0);

`ifdef LED_SHIFT_SEQ_STEP_EN
    assign w_step_req = w_edge[KEY_STEP] & ~r_running;
`else
    assign w_step_req = 1'b0;
`endif

    assign w_unused  = ^{w_edge[KEY_STEP], w_edge[KEY_INJ]};
    assign w_do_step = (w_tick | w_step_req) & ~w_clear & ~w_mode_chg;

    // Opposing speed keys in the same cycle cancel out
    always_comb begin
        w_speed_nxt = r_speed;
        if (w_edge[KEY_FAST] && !w_edge[KEY_SLOW] && (r_speed != SPEED_MAX)) begin
            w_speed_nxt = r_speed + 3'd1;
        end else if (w_edge[KEY_SLOW] && !w_edge[KEY_FAST] && (r_speed != 3'd0)) begin
            w_speed_nxt = r_speed - 3'd1;
        end
    end

    // Reload value 2^(DIV_BITS-speed)-1 is the all-ones pattern shifted right
    always_comb begin
        w_count_nxt = r_count;
        if (w_speed_nxt != r_speed) begin
            w_count_nxt = c_div_all_ones >> w_speed_nxt;
        end else if (r_running) begin
            w_count_nxt = (r_count == '0) ? (c_div_all_ones >> r_speed) : (r_count - c_div_one);
        end
    end

    assign w_running_nxt = r_running ^ w_edge[KEY_RUN];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode       <= SHIFT_IN;
            r_dir        <= 1'b0;
            r_running    <= 1'b1;
            r_speed      <= 3'd0;
            r_count      <= c_div_all_ones;
            r_step_pulse <= 1'b0;
        end else begin
            r_mode       <= w_mode_nxt;
            r_dir        <= w_dir_nxt;
            r_running    <= w_running_nxt;
            r_speed      <= w_speed_nxt;
            r_count      <= w_count_nxt;
            r_step_pulse <= w_do_step;
        end
    end

    // Priority: clear, then mode-entry load, then a step in the (new) direction
    always_comb begin
        w_mode_nxt = r_mode;
        w_dir_nxt  = w_dir_eff;
        w_op       = OP_HOLD;
        w_step_dir = w_dir_eff;
        w_load_val = SEED;
        if (w_clear) begin
            w_op       = OP_LOAD;
            w_load_val = SEED;
        end else if (w_mode_chg) begin
            w_mode_nxt = next_mode(r_mode);
            case (next_mode(r_mode))
                ROTATE: begin
                    if (w_led == '0) begin
                        w_op       = OP_LOAD;
                        w_load_val = c_led_one;
                    end
                end
                BOUNCE: begin
                    w_op       = OP_LOAD;
                    w_load_val = c_led_one;
                    w_dir_nxt  = 1'b1;
                end
                default: w_op = OP_HOLD;
            endcase
        end else if (w_do_step) begin
            case (r_mode)
                SHIFT_IN: w_op = OP_SHIFT_IN;
                ROTATE:   w_op = OP_ROTATE;
                BOUNCE: begin
                    w_op = OP_ROTATE;
                    if (w_led == '0) begin
                        w_op       = OP_LOAD;
                        w_load_val = c_led_one;
                    end else if (w_dir_eff && w_led[WIDTH-1]) begin
                        w_step_dir = 1'b0;
                        w_dir_nxt  = 1'b0;
                    end else if (!w_dir_eff && w_led[0]) begin
                        w_step_dir = 1'b1;
                        w_dir_nxt  = 1'b1;
                    end
                end
                default: w_op = OP_HOLD;
            endcase
        end
    end

    shift_reg_datapath #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_datapath (
        .clock    (clock),
        .reset_n  (reset_n),
        .op       (w_op),
        .dir      (w_step_dir),
        .in_bit   (w_inj),
        .load_val (w_load_val),
        .q        (w_led)
    );

    assign bus.led        = w_led;
    assign bus.mode       = r_mode;
    assign bus.dir        = r_dir;
    assign bus.running    = r_running;
    assign bus.speed      = r_speed;
    assign bus.step_pulse = r_step_pulse;

endmodule
`default_nettype wire
